// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte-stream requesters.
// Optional busy-handshake watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int NREQ           = 4,
   parameter int DataWidth      = 8,
   parameter int BURST_MAX      = 4,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*DataWidth-1:0] req_data,
   input  logic [NREQ-1:0]           req_last,
   output logic [NREQ-1:0]           req_ready,
   output logic [NREQ-1:0]           grant,
   output logic                      tx_start,
   output logic [DataWidth-1:0]      tx_data,
   input  logic                      tx_busy,
   output logic                      timeout_err
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(BURST_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACK, S_DONE} state_t;

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     owner_q, owner_nxt;
   logic [IDX_W-1:0]     rr_ptr, rr_nxt;
   logic [CNT_W-1:0]     byte_cnt, cnt_nxt;
   logic                 last_q, last_nxt;
   logic [NREQ-1:0]      grant_nxt, ready_nxt;
   logic                 tx_start_nxt, terr_nxt;
   logic [DataWidth-1:0] tx_data_nxt, owner_data;
   logic                 wd_hit;

   // First valid requester strictly after ptr, wrapping modulo NREQ.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] v,
                                                input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] pick;
      logic             found;
      int               idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && v[idx]) begin
            pick  = IDX_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign owner_data = req_data[int'(owner_q)*DataWidth +: DataWidth];

`ifdef UART_ARB_TIMEOUT_EN
   logic [31:0] wdog;

   always_ff @(posedge clk) begin
      if (rst) begin
         wdog <= '0;
      end else if (state_nxt != state && (state_nxt == S_ACK || state_nxt == S_DONE)) begin
         wdog <= '0;
      end else if (state == S_ACK || state == S_DONE) begin
         wdog <= wdog + 32'd1;
      end
   end

   assign wd_hit = (state == S_ACK || state == S_DONE) && (wdog == 32'(TIMEOUT_CYCLES - 1));
`else
   assign wd_hit = 1'b0;
`endif

   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner_q;
      rr_nxt       = rr_ptr;
      cnt_nxt      = byte_cnt;
      last_nxt     = last_q;
      grant_nxt    = grant;
      ready_nxt    = '0;
      tx_start_nxt = 1'b0;
      tx_data_nxt  = tx_data;
      terr_nxt     = 1'b0;
      case (state)
         S_IDLE: begin
            if (|req_valid) begin
               owner_nxt            = rr_pick(req_valid, rr_ptr);
               grant_nxt            = '0;
               grant_nxt[owner_nxt] = 1'b1;
               cnt_nxt              = '0;
               state_nxt            = S_LOAD;
            end
         end
         S_LOAD: begin
            if (!req_valid[owner_q]) begin
               grant_nxt = '0;
               rr_nxt    = owner_q;
               state_nxt = S_IDLE;
            end else if (!tx_busy) begin
               tx_start_nxt       = 1'b1;
               tx_data_nxt        = owner_data;
               ready_nxt[owner_q] = 1'b1;
               cnt_nxt            = byte_cnt + CNT_W'(1);
               last_nxt           = req_last[owner_q];
               state_nxt          = S_ACK;
            end
         end
         S_ACK: begin
            if (wd_hit) begin
               terr_nxt  = 1'b1;
               grant_nxt = '0;
               rr_nxt    = owner_q;
               state_nxt = S_IDLE;
            end else if (tx_busy) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (wd_hit) begin
               terr_nxt  = 1'b1;
               grant_nxt = '0;
               rr_nxt    = owner_q;
               state_nxt = S_IDLE;
            end else if (!tx_busy) begin
               // Release on end of message or exhausted burst; otherwise fetch next byte.
               if (last_q || byte_cnt == CNT_W'(BURST_MAX)) begin
                  grant_nxt = '0;
                  rr_nxt    = owner_q;
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_LOAD;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         owner_q     <= '0;
         rr_ptr      <= IDX_W'(NREQ - 1);
         byte_cnt    <= '0;
         last_q      <= 1'b0;
         grant       <= '0;
         req_ready   <= '0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         owner_q     <= owner_nxt;
         rr_ptr      <= rr_nxt;
         byte_cnt    <= cnt_nxt;
         last_q      <= last_nxt;
         grant       <= grant_nxt;
         req_ready   <= ready_nxt;
         tx_start    <= tx_start_nxt;
         tx_data     <= tx_data_nxt;
         timeout_err <= terr_nxt;
      end
   end

endmodule
